// File: rtl/inst_sram_slave_pkg.sv
// Shared constants for the instruction-SRAM responder: RAM window base, miss data, kseg mask.
// Latency: n/a (package only).
// Backpressure: n/a.
package inst_sram_slave_pkg;

    // Physical base of the boot/instruction RAM window (MIPS reset vector region).
    localparam logic [31:0] INST_RAM_BASE_PA = 32'h1fc00000;
    // Word returned for out-of-window reads; all-zero is the MIPS nop.
    localparam logic [31:0] NOP_INST         = 32'h00000000;
    // kseg0/kseg1 virtual -> physical: drop the top three address bits.
    localparam logic [31:0] KSEG_MASK        = 32'h1fffffff;

    // Where the registered read data comes from in the cycle after a request.
    typedef enum logic [1:0] {
        RSRC_ZERO = 2'd0,   // after reset, no request taken yet
        RSRC_BANK = 2'd1,   // last taken request hit the RAM window
        RSRC_ERR  = 2'd2    // last taken request was a read miss
    } rsrc_e;

    function automatic logic [31:0] kseg_to_pa(input logic [31:0] va);
        return va & KSEG_MASK;
    endfunction

endpackage

// File: rtl/inst_sram_slave_bank.sv
// Byte-enabled word RAM with one bus port (read or byte write) and one full-word preload write port.
// Latency: read/write data registered on rdata one cycle after req; write-first on both ports.
// Backpressure: none; every req and ld_we is accepted. rdata holds when req=0.
// Ports: clk; req/wen/idx/wdata bus access; ld_we/ld_idx/ld_data preload write; rdata registered output.
module sram_word_bank #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              req,
    input  logic [3:0]        wen,
    input  logic [ADDR_W-1:0] idx,
    input  logic [31:0]       wdata,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_idx,
    input  logic [31:0]       ld_data,
    output logic [31:0]       rdata
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [31:0] mem [DEPTH];
    logic [31:0] base_word;
    logic [31:0] merged_word;

    // A same-cycle preload to the bus index is forwarded, so the bus sees
    // the freshly loaded word; bus byte lanes are then merged over it.
    always_comb begin
        base_word = mem[idx];
        if (ld_we && (ld_idx == idx)) begin
            base_word = ld_data;
        end
        for (int i = 0; i < 4; i++) begin
            merged_word[8*i +: 8] = wen[i] ? wdata[8*i +: 8] : base_word[8*i +: 8];
        end
    end

    // The bus write is issued after the preload write so it wins on a collision.
    always_ff @(posedge clk) begin
        if (ld_we) begin
            mem[ld_idx] <= ld_data;
        end
        if (req && (wen != 4'b0000)) begin
            mem[idx] <= merged_word;
        end
        if (req) begin
            rdata <= merged_word;   // equals base_word for reads
        end
    end

endmodule

// File: rtl/inst_sram_slave.sv
// Instruction-SRAM responder: kseg translation, window check, sticky miss error, preload pointer.
// Latency: rdata valid exactly one cycle after an en request; holds while en=0.
// Backpressure: none; a request is accepted every cycle.
// Ports: clk/resetn; inst_sram_* fetch bus; ld_* sequential preload; err/err_addr sticky miss.
// Optional: INST_SRAM_STAT_EN adds saturating hit counters on stat_rd/stat_wr.
module inst_sram_slave
    import inst_sram_slave_pkg::*;
#(
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] BASE_PA  = INST_RAM_BASE_PA,
    parameter logic [31:0] ERR_DATA = NOP_INST
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_sram_en,
    input  logic [3:0]        inst_sram_wen,
    input  logic [31:0]       inst_sram_addr,
    input  logic [31:0]       inst_sram_wdata,
    output logic [31:0]       inst_sram_rdata,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic              ld_valid,
    input  logic [31:0]       ld_data,
    output logic              err,
    output logic [31:0]       err_addr
`ifdef INST_SRAM_STAT_EN
    ,
    output logic [31:0]       stat_rd,
    output logic [31:0]       stat_wr
`endif
);
    localparam int          DEPTH     = 2 ** ADDR_W;
    localparam logic [31:0] WIN_BYTES = 32'(DEPTH * 4);

    logic [31:0]       pa;
    logic [31:0]       off;
    logic              hit;
    logic [ADDR_W-1:0] idx;
    logic              bank_req;
    logic [31:0]       bank_rdata;
    logic [ADDR_W-1:0] ld_ptr;
    logic [ADDR_W-1:0] ld_idx;
    rsrc_e             rsrc;
    logic              unused_off_bits;

    // Unsigned offset compare also rejects addresses below the base (wraparound).
    assign pa       = kseg_to_pa(inst_sram_addr);
    assign off      = pa - BASE_PA;
    assign hit      = off < WIN_BYTES;
    assign idx      = off[ADDR_W+1:2];
    assign bank_req = inst_sram_en && hit;
    assign unused_off_bits = ^off[1:0];

    // ld_start in the same cycle as ld_valid redirects the write itself.
    assign ld_idx = ld_start ? ld_addr : ld_ptr;

    sram_word_bank #(.ADDR_W(ADDR_W)) u_bank (
        .clk     (clk),
        .req     (bank_req),
        .wen     (inst_sram_wen),
        .idx     (idx),
        .wdata   (inst_sram_wdata),
        .ld_we   (ld_valid),
        .ld_idx  (ld_idx),
        .ld_data (ld_data),
        .rdata   (bank_rdata)
    );

    // The RAM output register has no reset so it stays inferable; a small
    // resettable source select gives rdata its reset and miss values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rsrc <= RSRC_ZERO;
        end else if (inst_sram_en) begin
            if (hit) begin
                rsrc <= RSRC_BANK;
            end else if (inst_sram_wen == 4'b0000) begin
                rsrc <= RSRC_ERR;
            end
        end
    end

    always_comb begin
        inst_sram_rdata = 32'h0;
        case (rsrc)
            RSRC_BANK: inst_sram_rdata = bank_rdata;
            RSRC_ERR:  inst_sram_rdata = ERR_DATA;
            default:   inst_sram_rdata = 32'h0;
        endcase
    end

    // First miss is captured; later misses leave the record alone until reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err      <= 1'b0;
            err_addr <= 32'h0;
        end else if (inst_sram_en && !hit && !err) begin
            err      <= 1'b1;
            err_addr <= inst_sram_addr;
        end
    end

    // Pointer width equals the index width, so +1 wraps DEPTH-1 -> 0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ld_ptr <= '0;
        end else if (ld_valid) begin
            ld_ptr <= ld_idx + {{(ADDR_W-1){1'b0}}, 1'b1};
        end else if (ld_start) begin
            ld_ptr <= ld_addr;
        end
    end

`ifdef INST_SRAM_STAT_EN
    logic rd_hit;
    logic wr_hit;
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;

    assign rd_hit = bank_req && (inst_sram_wen == 4'b0000);
    assign wr_hit = bank_req && (inst_sram_wen != 4'b0000);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_cnt <= 32'h0;
            wr_cnt <= 32'h0;
        end else begin
            if (rd_hit && (rd_cnt != 32'hffffffff)) rd_cnt <= rd_cnt + 32'd1;
            if (wr_hit && (wr_cnt != 32'hffffffff)) wr_cnt <= wr_cnt + 32'd1;
        end
    end

    assign stat_rd = rd_cnt;
    assign stat_wr = wr_cnt;
`endif

endmodule
